// File: rtl/spi_cmd_ctrl.sv
// SPI command/transaction controller.
// Watches the SPI slave byte engine, which runs in the spi_clk domain, and
// decodes command/address/data frames. It turns them into single-byte
// read/write requests on the cart memory bus and supplies the next byte the
// slave shifts out.
module spi_cmd_ctrl #(
  parameter int ADDR_BYTES  = 3,
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              spi_busy,
  input  logic [7:0]        spi_in_byte,
  output logic [7:0]        spi_out_byte,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        status
);

  localparam int CNT_W = $clog2(ADDR_BYTES + 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, WR, WR_WAIT, RD_REQ, RD_WAIT, RD, STAT, DISCARD, WAIT_ABORT
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] busy_sync;
  logic                   cs_s, busy_s;
  logic                   cs_d, busy_d;
  logic                   byte_done, cs_fall;
  logic                   issue_wr, hold_req;

  state_t                 state;
  logic                   write_mode;
  logic [CNT_W-1:0]       addr_cnt;
  logic [ADDR_W-1:0]      addr;
  logic                   bad_cmd, overrun;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign busy_s    = busy_sync[SYNC_STAGES-1];
  assign byte_done = busy_d & ~busy_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign status    = {6'b0, bad_cmd, overrun};

  // A write issued this cycle, or a request still waiting for its ack, keeps
  // the bus transaction alive across a chip-select abort.
  assign issue_wr  = (state == WR) && byte_done;
  assign hold_req  = issue_wr || (mem_req && !mem_ack);

  // Bring cs_n and spi_busy into the clk domain; keep one delayed copy of each
  // for edge detection. Reset values are the idle levels of the pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      busy_sync <= '0;
      cs_d      <= 1'b1;
      busy_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      busy_sync <= {busy_sync[SYNC_STAGES-2:0], spi_busy};
      cs_d      <= cs_s;
      busy_d    <= busy_s;
    end
  end

  // Frame sequencer with registered bus/SPI outputs. The chip-select check at
  // the bottom runs after the per-state work, so a byte finishing in the same
  // cycle is still handled before the frame is torn down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      write_mode   <= 1'b0;
      addr_cnt     <= '0;
      addr         <= '0;
      bad_cmd      <= 1'b0;
      overrun      <= 1'b0;
      spi_out_byte <= 8'h00;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          mem_req <= 1'b0;
          if (cs_fall) begin
            state        <= CMD;
            spi_out_byte <= status;
            addr         <= '0;
            addr_cnt     <= '0;
          end
        end

        CMD: begin
          if (byte_done) begin
            spi_out_byte <= 8'h00;
            addr_cnt     <= '0;
            case (spi_in_byte)
              8'h02: begin
                write_mode <= 1'b1;
                state      <= ADDR;
              end
              8'h03: begin
                write_mode <= 1'b0;
                state      <= ADDR;
              end
              8'h05: begin
                // Status is also returned on the byte after the command.
                spi_out_byte <= status;
                state        <= STAT;
              end
              default: begin
                bad_cmd <= 1'b1;
                state   <= DISCARD;
              end
            endcase
          end
        end

        ADDR: begin
          if (byte_done) begin
            // Address arrives MSB first; excess upper bits fall off the top.
            addr <= ADDR_W'({addr, spi_in_byte});
            if (addr_cnt == CNT_W'(ADDR_BYTES - 1)) begin
              state <= write_mode ? WR : RD_REQ;
            end else begin
              addr_cnt <= addr_cnt + CNT_W'(1);
            end
          end
        end

        WR: begin
          if (byte_done) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= spi_in_byte;
            state     <= WR_WAIT;
          end
        end

        WR_WAIT: begin
          // A byte landing while the bus is busy is dropped and flagged.
          if (byte_done) overrun <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            addr    <= addr + ADDR_W'(1);
            state   <= WR;
          end
        end

        RD_REQ: begin
          // No new prefetch once the master has released chip select.
          if (!cs_s) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= addr;
            mem_wdata <= 8'h00;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (byte_done) overrun <= 1'b1;
          if (mem_ack) begin
            spi_out_byte <= mem_rdata;
            mem_req      <= 1'b0;
            addr         <= addr + ADDR_W'(1);
            state        <= RD;
          end
        end

        RD: begin
          // The byte just shifted out; fetch the one for the next transfer.
          if (byte_done) state <= RD_REQ;
        end

        STAT: begin
          if (byte_done) begin
            bad_cmd      <= 1'b0;
            overrun      <= 1'b0;
            spi_out_byte <= 8'h00;
            state        <= DISCARD;
          end
        end

        DISCARD: spi_out_byte <= 8'h00;

        WAIT_ABORT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // End of frame: finish any bus transaction in flight, then go idle.
      if (cs_s && state != IDLE && state != WAIT_ABORT) begin
        if (hold_req) begin
          state <= WAIT_ABORT;
        end else begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed frame table, hand-written
// abort/overrun/reset sequences, and random frames against a frame-level model.
module tb_spi_cmd_ctrl;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          spi_busy = 1'b0;
  logic [7:0]    spi_in_byte = 8'h00;
  logic [7:0]    spi_out_byte;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    status;

  spi_cmd_ctrl #(.ADDR_BYTES(3), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .spi_busy(spi_busy),
    .spi_in_byte(spi_in_byte), .spi_out_byte(spi_out_byte),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } req_t;

  typedef struct {
    logic [7:0] b[6];
    int         nb;
    logic [7:0] o[6];
    int         nreq;
    req_t       r[2];
    logic [7:0] st;
  } vec_t;

  req_t       got_q[$];
  req_t       exp_q[$];
  logic [7:0] frame_b[$];
  logic [7:0] frame_o[$];
  logic [7:0] exp_o[$];
  logic [7:0] ovr[int];
  logic [7:0] m_status = 8'h00;
  int         ack_delay = 2;
  int         checks = 0;
  int         passes = 0;

  function automatic logic [7:0] rd_val(input logic [AW-1:0] a);
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory responder: logs each request, acks after ack_delay cycles.
  req_t cur;
  bit   live;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        cur.we = mem_we; cur.addr = mem_addr; cur.data = mem_wdata;
        got_q.push_back(cur);
        live = 1'b1;
        for (int i = 1; i < ack_delay && live; i++) begin
          @(negedge clk);
          if (mem_req !== 1'b1) live = 1'b0;
        end
        if (live) begin
          chk("req_stable_addr", 32'(mem_addr), 32'(cur.addr));
          chk("req_stable_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) chk("req_stable_data", 32'(mem_wdata), 32'(cur.data));
          mem_rdata = rd_val(mem_addr);
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
          mem_rdata = 8'h00;
          chk("req_drop", 32'(mem_req), 32'(0));
        end
      end
    end
  end

  task automatic xfer(input logic [7:0] b, input int gap);
    @(negedge clk);
    frame_o.push_back(spi_out_byte);
    spi_in_byte = b;
    spi_busy = 1'b1;
    repeat (8) @(negedge clk);
    spi_busy = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_high(input int w);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (w) @(negedge clk);
  endtask

  task automatic run_frame();
    frame_o = {};
    got_q.delete();
    cs_low();
    foreach (frame_b[i]) xfer(frame_b[i], 12);
    cs_high(ack_delay + 12);
  endtask

  // Frame-level model: what a whole frame must produce, given the command.
  task automatic model_frame();
    int nb;
    int n;
    logic [AW-1:0] a;
    nb = frame_b.size();
    exp_o = {};
    exp_q = {};
    for (int i = 0; i < nb; i++) exp_o.push_back(8'h00);
    exp_o[0] = m_status;
    if (frame_b[0] == 8'h02 || frame_b[0] == 8'h03) begin
      if (nb >= 4) begin
        a = {frame_b[1], frame_b[2], frame_b[3]};
        n = nb - 4;
        if (frame_b[0] == 8'h02) begin
          for (int k = 0; k < n; k++)
            exp_q.push_back('{1'b1, AW'(a + AW'(k)), frame_b[4+k]});
        end else begin
          for (int k = 0; k <= n; k++)
            exp_q.push_back('{1'b0, AW'(a + AW'(k)), 8'h00});
          for (int k = 0; k < n; k++) exp_o[4+k] = rd_val(AW'(a + AW'(k)));
        end
      end
    end else if (frame_b[0] == 8'h05) begin
      if (nb >= 2) begin
        exp_o[1] = m_status;
        m_status = 8'h00;
      end
    end else begin
      m_status = m_status | 8'h02;
    end
  endtask

  task automatic compare(input string tag, input int exp_n, input logic [7:0] exp_st);
    foreach (exp_o[i])
      chk($sformatf("%s out[%0d]", tag, i), 32'(frame_o[i]), 32'(exp_o[i]));
    chk({tag, " nreq"}, got_q.size(), exp_n);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s req%0d we", tag, i), 32'(got_q[i].we), 32'(exp_q[i].we));
      chk($sformatf("%s req%0d addr", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      if (exp_q[i].we)
        chk($sformatf("%s req%0d data", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
    end
    chk({tag, " status"}, 32'(status), 32'(exp_st));
  endtask

  task automatic model_run(input string tag);
    model_frame();
    run_frame();
    compare(tag, exp_q.size(), m_status);
  endtask

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    logic [AW-1:0] ra;
    int kind, n;

    tbl[0] = '{'{8'h02, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB}, 6,
               '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2,
               '{'{1'b1, 24'h000010, 8'hAA}, '{1'b1, 24'h000011, 8'hBB}}, 8'h00};
    tbl[1] = '{'{8'h03, 8'h00, 8'h01, 8'hFF, 8'h11, 8'h22}, 6,
               '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3}, 3,
               '{'{1'b0, 24'h0001FF, 8'h00}, '{1'b0, 24'h000200, 8'h00}}, 8'h00};
    tbl[2] = '{'{8'h7E, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00}, 4,
               '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0,
               '{'{1'b0, 24'h0, 8'h00}, '{1'b0, 24'h0, 8'h00}}, 8'h02};
    tbl[3] = '{'{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2,
               '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 0,
               '{'{1'b0, 24'h0, 8'h00}, '{1'b0, 24'h0, 8'h00}}, 8'h00};
    tbl[4] = '{'{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2,
               '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0,
               '{'{1'b0, 24'h0, 8'h00}, '{1'b0, 24'h0, 8'h00}}, 8'h00};
    tbl[5] = '{'{8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02}, 6,
               '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2,
               '{'{1'b1, 24'hFFFFFF, 8'h01}, '{1'b1, 24'h000000, 8'h02}}, 8'h00};
    ovr[32'h1FF] = 8'h5A;
    ovr[32'h200] = 8'hC3;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 32'(0));
    chk("rst mem_we", 32'(mem_we), 32'(0));
    chk("rst mem_addr", 32'(mem_addr), 32'(0));
    chk("rst mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst spi_out", 32'(spi_out_byte), 32'(0));
    chk("rst status", 32'(status), 32'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frame table
    for (int v = 0; v < 6; v++) begin
      ack_delay = 2;
      frame_b = {};
      exp_o = {};
      exp_q = {};
      for (int i = 0; i < tbl[v].nb; i++) begin
        frame_b.push_back(tbl[v].b[i]);
        exp_o.push_back(tbl[v].o[i]);
      end
      for (int i = 0; i < tbl[v].nreq && i < 2; i++) exp_q.push_back(tbl[v].r[i]);
      run_frame();
      compare($sformatf("vec%0d", v), tbl[v].nreq, tbl[v].st);
      m_status = tbl[v].st;
    end

    // Overrun: first write held off 40 cycles while the next byte completes
    ack_delay = 40;
    frame_b = '{8'h02, 8'h00, 8'h00, 8'h20, 8'hA1, 8'hA2};
    run_frame();
    chk("ovr nreq", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("ovr addr", 32'(got_q[0].addr), 32'h20);
      chk("ovr data", 32'(got_q[0].data), 32'hA1);
    end
    chk("ovr status", 32'(status), 32'h01);
    m_status = 8'h01;
    ack_delay = 2;
    frame_b = '{8'h05, 8'h00};
    model_run("ovr_stat");

    // Abort after the second address byte, then a clean frame
    got_q.delete();
    frame_o = {};
    cs_low();
    xfer(8'h02, 12); xfer(8'h00, 12); xfer(8'h00, 12);
    cs_high(10);
    chk("abort_addr nreq", got_q.size(), 0);
    frame_b = '{8'h02, 8'h00, 8'h00, 8'h30, 8'h55};
    model_run("after_abort");

    // Chip select released during RD_WAIT: request held until ack
    ack_delay = 30;
    got_q.delete();
    frame_o = {};
    cs_low();
    xfer(8'h03, 12); xfer(8'h00, 12); xfer(8'h00, 12); xfer(8'h40, 12);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_rd hold", 32'(mem_req), 32'(1));
    repeat (40) @(negedge clk);
    chk("abort_rd released", 32'(mem_req), 32'(0));
    chk("abort_rd nreq", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("abort_rd addr", 32'(got_q[0].addr), 32'h40);
      chk("abort_rd we", 32'(got_q[0].we), 32'(0));
    end
    ack_delay = 2;
    frame_b = '{8'h05, 8'h00};
    model_run("after_rd_abort");

    // Reset for one clock during WR_WAIT, with a flag set beforehand
    frame_b = '{8'h7E};
    model_run("pre_rst_bad");
    ack_delay = 40;
    got_q.delete();
    frame_o = {};
    cs_low();
    xfer(8'h02, 12); xfer(8'h00, 12); xfer(8'h00, 12); xfer(8'h50, 12);
    xfer(8'h77, 4);
    chk("rst_mid pre mem_req", 32'(mem_req), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid mem_req", 32'(mem_req), 32'(0));
    chk("rst_mid mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mid spi_out", 32'(spi_out_byte), 32'(0));
    chk("rst_mid status", 32'(status), 32'(0));
    m_status = 8'h00;
    cs_high(10);
    ack_delay = 2;
    frame_b = '{8'h05, 8'h00};
    model_run("after_rst");

    // Random frames against the model
    for (int f = 0; f < 30; f++) begin
      ack_delay = $urandom_range(1, 4);
      kind = $urandom_range(0, 3);
      frame_b = {};
      case (kind)
        0, 1: begin
          frame_b.push_back(kind == 0 ? 8'h02 : 8'h03);
          ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : AW'($urandom);
          frame_b.push_back(ra[23:16]);
          frame_b.push_back(ra[15:8]);
          frame_b.push_back(ra[7:0]);
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) frame_b.push_back(8'($urandom));
        end
        2: begin
          frame_b.push_back(8'h05);
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) frame_b.push_back(8'($urandom));
        end
        default: begin
          c = 8'($urandom);
          while (c == 8'h02 || c == 8'h03 || c == 8'h05) c = 8'($urandom);
          frame_b.push_back(c);
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) frame_b.push_back(8'($urandom));
        end
      endcase
      model_run($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command/transaction controller that sequences the SPI slave byte engine on the cart.
- Detects completed bytes from the slave's busy flag, which is in the spi_clk domain and synchronized internally.
- Parses a command/address/data frame and issues single-byte read/write requests to the cart memory bus.
- Supplies the next byte that the slave shifts out.
- Sits between the SPI slave and the SRAM/ROM arbiter. All logic is in the clk domain.

Parameters:
- ADDR_BYTES, 3, number of address bytes following the command byte, MSB first
- ADDR_W, 24, memory address width; must be <= 8*ADDR_BYTES; upper address bits are truncated
- SYNC_STAGES, 2, flip-flop stages on the cs_n and spi_busy synchronizers (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cs_n  in  1  SPI chip select from the master, asynchronous, active-low
- spi_busy  in  1  busy from the SPI slave; high while a byte is shifting
- spi_in_byte  in  8  received byte from the SPI slave; stable once busy falls
- spi_out_byte  out  8  byte for the SPI slave to shift out on the next transfer
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1=write, 0=read; valid while mem_req
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  8  write data
- mem_ack  in  1  single-cycle completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  8  read data
- status  out  8  {6'b0, bad_cmd, overrun}, sticky flags

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE, all outputs 0, address register 0, sync chains cleared to idle values (cs_n=1, busy=0).
- Synchronization: cs_s and busy_s come from SYNC_STAGES-deep chains. byte_done is a 1-cycle pulse on the falling edge of busy_s. The controller captures spi_in_byte in the byte_done cycle.
- Framing: cs_s=1 forces state=IDLE on the next clk, except that an outstanding mem_req is held until mem_ack (state WAIT_ABORT), then IDLE. The address counter is not preserved across frames.
- cs_s falling while in IDLE goes to CMD. spi_out_byte is set to status for the command byte.
- CMD, on byte_done:
  - 0x02 -> ADDR, write mode
  - 0x03 -> ADDR, read mode
  - 0x05 -> STAT
  - any other value -> set bad_cmd, go to DISCARD
- ADDR: shift each received byte into the address register, MSB first. After ADDR_BYTES bytes:
  - write mode -> WR
  - read mode -> RD_REQ
- WR: each byte_done asserts mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=byte, then goes to WR_WAIT. On mem_ack: mem_req=0, addr=addr+1 (wraps modulo 2^ADDR_W), return to WR.
- RD_REQ: assert mem_req=1, mem_we=0, then go to RD_WAIT. On mem_ack: spi_out_byte=mem_rdata, addr+1, go to RD. In RD, byte_done goes to RD_REQ for the next address (prefetch for the following transfer).
- Overrun: byte_done while in WR_WAIT or RD_WAIT:
  - sets overrun
  - the write byte is dropped
  - the pending request completes normally
  - no second request is queued
- STAT: byte_done clears both status flags, goes to DISCARD, spi_out_byte=0x00.
- DISCARD: ignore all bytes until cs_s=1. spi_out_byte=0x00.
- mem_req is never asserted in IDLE, CMD, ADDR, STAT or DISCARD.
- mem_req/mem_we/mem_addr/mem_wdata are stable from assertion until the mem_ack cycle inclusive. mem_req drops the cycle after mem_ack.
- Simultaneous events:
  - mem_ack and cs_s rise in the same cycle: ack is consumed, go to IDLE.
  - byte_done and cs_s rise in the same cycle: byte_done is processed first (a write is issued), then the abort rules apply.
- Status flags persist across frames; only a STAT command or reset clears them.
- Latency: mem_req asserts 1 clk after byte_done, which is SYNC_STAGES+1 clk after busy falls at the pin.

Test Plan:
- Write frame: cs_n low, bytes 02 00 00 10 AA BB, cs_n high. Required: two requests, (we=1, addr 0x000010, data 0xAA) and (we=1, addr 0x000011, data 0xBB); status=0x00.
- Read frame: bytes 03 00 01 FF xx xx, memory returns 0x5A at 0x0001FF and 0xC3 at 0x000200. Required: spi_out_byte=0x5A before the 5th byte and 0xC3 before the 6th; addresses 0x0001FF, 0x000200.
- Bad command: byte 0x7E then 3 more bytes. Required: no mem_req; status=0x02. A following frame with command 05 returns 0x02 on the next byte; the frame after that reads 0x00.
- Overrun: write frame with mem_ack delayed 40 clk while the next byte completes. Required: only the first byte is written; status bit0=1; no lost request.
- Abort: cs_n high after the 2nd address byte. Required: IDLE, no mem_req. cs_n high during RD_WAIT: mem_req held until ack, then IDLE.
- Reset mid-operation: rst_n=0 for 1 clk during WR_WAIT. Required: next clk mem_req=0, spi_out_byte=0x00, status=0x00, IDLE.
